// File: rtl/reversalmb_module_partner_pkg.sv
// Sideband message codes shared by the MBINIT step controllers.
// Message codes are common to every step; the lane width is shared as well.
package reversalmb_module_partner_pkg;

    typedef enum logic [3:0] {
        SB_NONE             = 4'b0000,
        SB_INIT_REQ         = 4'b0001,
        SB_INIT_RESP        = 4'b0010,
        SB_CLEAR_ERROR_REQ  = 4'b0011,
        SB_CLEAR_ERROR_RESP = 4'b0100,
        SB_RESULT_REQ       = 4'b0101,
        SB_RESULT_RESP      = 4'b0110,
        SB_DONE_REQ         = 4'b0111,
        SB_DONE_RESP        = 4'b1000
    } sb_msg_e;

    localparam int unsigned LANES = 16;

endpackage

// File: rtl/reversalmb_module_partner.sv
// MBINIT.REVERSALMB partner-side controller: answers init / clear-error /
// result / done requests and gates the RX lane comparator window.
module reversalmb_module_partner
    import reversalmb_module_partner_pkg::*;
(
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             i_MBINIT_REPAIRVAL_end,
    input  logic [3:0]       i_RX_SbMessage,
    input  logic             i_msg_valid,
    input  logic             i_Busy_SideBand,
    input  logic             i_falling_edge_busy,
    input  logic [LANES-1:0] i_lane_results,
    input  logic             i_compare_done,
    output logic [3:0]       o_TX_SbMessage,
    output logic             o_ValidOutData,
    output logic [LANES-1:0] o_TX_data,
    output logic             o_clear_error,
    output logic             o_rx_compare_en,
    output logic             o_MBINIT_REVERSALMB_end
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_INIT = 4'd1,
        ST_BUSY_INIT = 4'd2,
        ST_INIT_RESP = 4'd3,
        ST_WAIT_MSG  = 4'd4,
        ST_BUSY_CLR  = 4'd5,
        ST_CLR_RESP  = 4'd6,
        ST_WAIT_CMP  = 4'd7,
        ST_BUSY_RES  = 4'd8,
        ST_RES_RESP  = 4'd9,
        ST_BUSY_DONE = 4'd10,
        ST_DONE_RESP = 4'd11,
        ST_DONE      = 4'd12
    } state_e;

    state_e           r_state;
    state_e           w_next;
    logic             w_enable;
    logic             w_enter_resp;
    logic [3:0]       w_resp_code;
    logic             w_latch;
    logic             w_clr_exit;

    logic [3:0]       r_tx_msg;
    logic             r_valid;
    logic [LANES-1:0] r_tx_data;
    logic             r_clear_error;
    logic             r_cmp_en;
    logic             r_end;

    assign w_enable = i_MBINIT_REPAIRVAL_end;

    always_comb begin
        w_next = r_state;
        if (!w_enable) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: w_next = ST_WAIT_INIT;
                ST_WAIT_INIT: begin
                    if (i_msg_valid && (i_RX_SbMessage == SB_INIT_REQ))
                        w_next = ST_BUSY_INIT;
                end
                ST_BUSY_INIT: begin
                    if (!i_Busy_SideBand)
                        w_next = ST_INIT_RESP;
                end
                ST_INIT_RESP: begin
                    if (i_falling_edge_busy)
                        w_next = ST_WAIT_MSG;
                end
                ST_WAIT_MSG: begin
                    if (i_msg_valid) begin
                        if (i_RX_SbMessage == SB_CLEAR_ERROR_REQ)
                            w_next = ST_BUSY_CLR;
                        else if (i_RX_SbMessage == SB_RESULT_REQ)
                            w_next = ST_WAIT_CMP;
                        else if (i_RX_SbMessage == SB_DONE_REQ)
                            w_next = ST_BUSY_DONE;
                    end
                end
                ST_BUSY_CLR: begin
                    if (!i_Busy_SideBand)
                        w_next = ST_CLR_RESP;
                end
                ST_CLR_RESP: begin
                    if (i_falling_edge_busy)
                        w_next = ST_WAIT_MSG;
                end
                ST_WAIT_CMP: begin
                    if (i_compare_done)
                        w_next = ST_BUSY_RES;
                end
                ST_BUSY_RES: begin
                    if (!i_Busy_SideBand)
                        w_next = ST_RES_RESP;
                end
                ST_RES_RESP: begin
                    if (i_falling_edge_busy)
                        w_next = ST_WAIT_MSG;
                end
                ST_BUSY_DONE: begin
                    if (!i_Busy_SideBand)
                        w_next = ST_DONE_RESP;
                end
                ST_DONE_RESP: begin
                    if (i_falling_edge_busy)
                        w_next = ST_DONE;
                end
                ST_DONE: w_next = ST_DONE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Response code belonging to the state being entered; zero elsewhere.
    always_comb begin
        w_resp_code = SB_NONE;
        unique case (w_next)
            ST_INIT_RESP: w_resp_code = SB_INIT_RESP;
            ST_CLR_RESP:  w_resp_code = SB_CLEAR_ERROR_RESP;
            ST_RES_RESP:  w_resp_code = SB_RESULT_RESP;
            ST_DONE_RESP: w_resp_code = SB_DONE_RESP;
            default:      w_resp_code = SB_NONE;
        endcase
    end

    assign w_enter_resp = (w_resp_code != SB_NONE) && (w_next != r_state);
    assign w_latch      = (r_state == ST_WAIT_CMP) && (w_next == ST_BUSY_RES);
    assign w_clr_exit   = (r_state == ST_CLR_RESP) && (w_next == ST_WAIT_MSG);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_tx_msg      <= '0;
            r_valid       <= 1'b0;
            r_tx_data     <= '0;
            r_clear_error <= 1'b0;
            r_cmp_en      <= 1'b0;
            r_end         <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_valid       <= w_enter_resp;
            r_tx_msg      <= w_enter_resp ? w_resp_code : 4'b0000;
            r_clear_error <= w_enter_resp && (w_next == ST_CLR_RESP);
            r_end         <= (w_next == ST_DONE);
            // Enable low forces IDLE, which also suppresses the pulses above.
            if (!w_enable) begin
                r_tx_data <= '0;
                r_cmp_en  <= 1'b0;
            end else begin
                if (w_latch)
                    r_tx_data <= i_lane_results;
                if (w_clr_exit)
                    r_cmp_en <= 1'b1;
                else if (w_latch)
                    r_cmp_en <= 1'b0;
            end
        end
    end

    assign o_TX_SbMessage          = r_tx_msg;
    assign o_ValidOutData          = r_valid;
    assign o_TX_data               = r_tx_data;
    assign o_clear_error           = r_clear_error;
    assign o_rx_compare_en         = r_cmp_en;
    assign o_MBINIT_REVERSALMB_end = r_end;

endmodule

// File: tb/tb_reversalmb_module_partner.sv
// Directed bench for the REVERSALMB partner controller: protocol-level model
// checked every cycle, plus literal checks at the key points of each scenario.
module tb_reversalmb_module_partner;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  rx_msg = '0;
    logic        msg_valid = 1'b0;
    logic        busy = 1'b0;
    logic        fe_busy = 1'b0;
    logic [15:0] lanes = '0;
    logic        cmp_done = 1'b0;
    logic [3:0]  tx_msg;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        clr_err;
    logic        cmp_en;
    logic        step_end;

    int n_checks = 0;
    int n_fail = 0;

    reversalmb_module_partner dut (
        .CLK                     (CLK),
        .rst_n                   (rst_n),
        .i_MBINIT_REPAIRVAL_end  (en),
        .i_RX_SbMessage          (rx_msg),
        .i_msg_valid             (msg_valid),
        .i_Busy_SideBand         (busy),
        .i_falling_edge_busy     (fe_busy),
        .i_lane_results          (lanes),
        .i_compare_done          (cmp_done),
        .o_TX_SbMessage          (tx_msg),
        .o_ValidOutData          (tx_valid),
        .o_TX_data               (tx_data),
        .o_clear_error           (clr_err),
        .o_rx_compare_en         (cmp_en),
        .o_MBINIT_REVERSALMB_end (step_end)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol-level model: a response is "sent" once TX is free, then
    // acknowledged by the busy falling edge, after which we resume at m_after.
    typedef enum {P_OFF, P_WAIT_INIT, P_SEND, P_ACK, P_CMD, P_CMP, P_FIN} phase_e;
    phase_e      m_phase = P_OFF;
    phase_e      m_after = P_OFF;
    logic [3:0]  m_code = '0;
    logic [3:0]  e_msg = '0;
    logic        e_valid = 1'b0;
    logic        e_clr = 1'b0;
    logic [15:0] e_data = '0;
    logic        e_cmp_en = 1'b0;
    logic        e_end = 1'b0;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_OFF; m_code = '0; e_msg = '0; e_valid = 0;
            e_clr = 0; e_data = '0; e_cmp_en = 0; e_end = 0;
        end else begin
            e_msg = '0; e_valid = 0; e_clr = 0;
            if (!en) begin
                m_phase = P_OFF; e_data = '0; e_cmp_en = 0;
            end else begin
                case (m_phase)
                    P_OFF: m_phase = P_WAIT_INIT;
                    P_WAIT_INIT:
                        if (msg_valid && rx_msg == 4'd1) begin
                            m_phase = P_SEND; m_code = 4'd2; m_after = P_CMD;
                        end
                    P_SEND:
                        if (!busy) begin
                            e_valid = 1; e_msg = m_code; e_clr = (m_code == 4'd4);
                            m_phase = P_ACK;
                        end
                    P_ACK:
                        if (fe_busy) begin
                            if (m_code == 4'd4) e_cmp_en = 1;
                            m_phase = m_after;
                        end
                    P_CMD:
                        if (msg_valid) begin
                            if (rx_msg == 4'd3) begin
                                m_phase = P_SEND; m_code = 4'd4; m_after = P_CMD;
                            end else if (rx_msg == 4'd5) begin
                                m_phase = P_CMP;
                            end else if (rx_msg == 4'd7) begin
                                m_phase = P_SEND; m_code = 4'd8; m_after = P_FIN;
                            end
                        end
                    P_CMP:
                        if (cmp_done) begin
                            e_data = lanes; e_cmp_en = 0;
                            m_phase = P_SEND; m_code = 4'd6; m_after = P_CMD;
                        end
                    default: ;
                endcase
            end
            e_end = (m_phase == P_FIN);
        end
    end

    always @(negedge CLK) begin
        chk("tx_msg", {12'h0, tx_msg}, {12'h0, e_msg});
        chk("valid", {15'h0, tx_valid}, {15'h0, e_valid});
        chk("clear_error", {15'h0, clr_err}, {15'h0, e_clr});
        chk("tx_data", tx_data, e_data);
        chk("compare_en", {15'h0, cmp_en}, {15'h0, e_cmp_en});
        chk("step_end", {15'h0, step_end}, {15'h0, e_end});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_msg(input logic [3:0] code);
        rx_msg = code; msg_valid = 1'b1;
        tick();
        rx_msg = '0; msg_valid = 1'b0;
    endtask

    task automatic wait_valid(input logic [3:0] code, input string name);
        int waited = 0;
        while (!tx_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk({name, "_seen"}, {15'h0, tx_valid}, 16'h1);
        chk({name, "_code"}, {12'h0, tx_msg}, {12'h0, code});
    endtask

    // TX busy for two cycles after a response, then the completion pulse.
    task automatic ack();
        busy = 1'b1;
        tick();
        chk("valid_one_cycle", {15'h0, tx_valid}, 16'h0);
        tick();
        busy = 1'b0; fe_busy = 1'b1;
        tick();
        fe_busy = 1'b0;
    endtask

    task automatic clear_round();
        send_msg(4'd3);
        wait_valid(4'd4, "clr_resp");
        chk("clear_pulse", {15'h0, clr_err}, 16'h1);
        ack();
        chk("cmp_en_after_clr", {15'h0, cmp_en}, 16'h1);
    endtask

    task automatic result_round(input logic [15:0] val);
        lanes = val; cmp_done = 1'b1;
        send_msg(4'd5);
        wait_valid(4'd6, "res_resp");
        chk("res_data", tx_data, val);
        chk("res_cmp_en", {15'h0, cmp_en}, 16'h0);
        cmp_done = 1'b0;
        ack();
    endtask

    task automatic do_init();
        en = 1'b1;
        tick(); tick();
        send_msg(4'd1);
        wait_valid(4'd2, "init_resp");
        ack();
    endtask

    initial begin
        #1;
        chk("rst_valid", {15'h0, tx_valid}, 16'h0);
        chk("rst_data", tx_data, 16'h0);
        #22 rst_n = 1'b1;
        tick(); tick();
        chk("idle_no_enable_end", {15'h0, step_end}, 16'h0);

        // Init handshake with TX initially busy.
        en = 1'b1;
        tick(); tick();
        busy = 1'b1;
        send_msg(4'd1);
        tick(); tick();
        chk("held_while_busy", {15'h0, tx_valid}, 16'h0);
        busy = 1'b0;
        wait_valid(4'd2, "init_resp");
        ack();
        send_msg(4'd9);
        send_msg(4'd1);
        tick();
        chk("ignored_codes", {15'h0, tx_valid}, 16'h0);

        // Clear, then result with a 5-cycle comparator stall.
        clear_round();
        lanes = 16'hFF0F; cmp_done = 1'b0;
        send_msg(4'd5);
        repeat (5) begin
            chk("stall_no_valid", {15'h0, tx_valid}, 16'h0);
            chk("stall_cmp_en", {15'h0, cmp_en}, 16'h1);
            tick();
        end
        cmp_done = 1'b1;
        wait_valid(4'd6, "stall_res");
        chk("stall_data", tx_data, 16'hFF0F);
        chk("stall_cmp_en_low", {15'h0, cmp_en}, 16'h0);
        cmp_done = 1'b0;
        ack();

        // Two more rounds, result ready before the request, then done.
        clear_round();
        result_round(16'h00FF);
        clear_round();
        result_round(16'hFFFF);
        send_msg(4'd7);
        wait_valid(4'd8, "done_resp");
        ack();
        chk("done_end", {15'h0, step_end}, 16'h1);
        chk("done_data", tx_data, 16'hFFFF);
        tick(); tick();
        chk("done_end_held", {15'h0, step_end}, 16'h1);
        en = 1'b0;
        tick();
        chk("disable_end", {15'h0, step_end}, 16'h0);
        chk("disable_data", tx_data, 16'h0);

        // Enable drop while waiting in BUSY_RES.
        do_init();
        clear_round();
        busy = 1'b1; lanes = 16'hA5C3; cmp_done = 1'b1;
        send_msg(4'd5);
        tick();
        chk("busyres_latched", tx_data, 16'hA5C3);
        en = 1'b0; busy = 1'b0; cmp_done = 1'b0;
        tick();
        chk("busyres_no_valid", {15'h0, tx_valid}, 16'h0);
        chk("busyres_data_clr", tx_data, 16'h0);
        tick();
        chk("busyres_still_quiet", {15'h0, tx_valid}, 16'h0);

        // Asynchronous reset mid-WAIT_CMP.
        do_init();
        clear_round();
        lanes = 16'h1234;
        send_msg(4'd5);
        tick();
        chk("pre_rst_cmp_en", {15'h0, cmp_en}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cmp_en", {15'h0, cmp_en}, 16'h0);
        chk("async_msg", {12'h0, tx_msg}, 16'h0);
        chk("async_data", tx_data, 16'h0);
        chk("async_end", {15'h0, step_end}, 16'h0);
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
